// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Enable-vector indices give each stage register a fixed bit position.
package pipeline_ctrl_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

   localparam int MULT_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 32;

   localparam int EN_PC    = 0;
   localparam int EN_IFID  = 1;
   localparam int EN_IDEX  = 2;
   localparam int EN_EXMEM = 3;
   localparam int EN_MEMWB = 4;
   localparam int EN_W     = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_timer.sv
// Multiply/divide EX-occupancy timer: loads the op length on issue,
// counts down on every non-held cycle and flags the final busy cycle.
module mdu_timer
   import pipeline_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic div,
   input  logic hold,
   output logic busy,
   output logic done
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;

   mdu_state_t      state;
   logic [CW-1:0]   count;

   // The counter holds the number of busy cycles still to go after this one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count <= div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                  state <= MDU_BUSY;
               end
            end
            MDU_BUSY: begin
               if (!hold) begin
                  if (count == '0)
                     state <= IDLE;
                  else
                     count <= count - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == MDU_BUSY);
   assign done = busy && (count == '0) && !hold;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: resolves memory
// freeze, taken branches, load-use, MDU occupancy and jumps into stage enables.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             id_mdu_start,
   input  logic             id_mdu_div,
   input  logic             id_mdu_use,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             mdu_busy,
   output logic             mdu_done,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WW = ($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic            freeze;
   logic            load_use;
   logic            mdu_hz;
   logic            mdu_issue;
   logic [EN_W-1:0] en;
   logic            ifid_flush_c;
   logic            idex_flush_c;
   logic [WW-1:0]   wait_cnt;

   assign freeze   = mem_req && !mem_ready;
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
   assign mdu_hz   = mdu_busy && id_mdu_use;

   always_comb begin
      en           = '1;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      if (freeze) begin
         en = '0;
      end else if (ex_branch_taken) begin
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
      end else if (mdu_hz || load_use) begin
         en[EN_PC]    = 1'b0;
         en[EN_IFID]  = 1'b0;
         idex_flush_c = 1'b1;
      end else if (id_jump) begin
         ifid_flush_c = 1'b1;
      end
   end

   assign pc_we      = en[EN_PC];
   assign ifid_we    = en[EN_IFID];
   assign idex_we    = en[EN_IDEX];
   assign exmem_we   = en[EN_EXMEM];
   assign memwb_we   = en[EN_MEMWB];
   assign ifid_flush = ifid_flush_c;
   assign idex_flush = idex_flush_c;

   // An op issues only when it actually leaves ID into EX this cycle.
   assign mdu_issue = id_mdu_start && !freeze && !ex_branch_taken && !mdu_hz && !load_use;

   mdu_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdu_timer (
      .clk   (clk),
      .rst   (rst),
      .start (mdu_issue),
      .div   (id_mdu_div),
      .hold  (freeze),
      .busy  (mdu_busy),
      .done  (mdu_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_err     <= 1'b0;
         stall_count <= '0;
      end else begin
         if (freeze) begin
            if (wait_cnt != WW'(MEM_TIMEOUT))
               wait_cnt <= wait_cnt + WW'(1);
            if (wait_cnt >= WW'(MEM_TIMEOUT - 1))
               mem_err <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (!pc_we && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken branches, jumps, multi-cycle multiply/divide occupancy and data-memory wait states into one consistent per-cycle control vector. It sits beside the datapath, takes decode/execute status, and owns the IF/ID `hazard` flush line.

## Interface
Parameters:
- MULT_CYCLES, 4, EX-occupancy cycles of a mult/multu
- DIV_CYCLES, 32, EX-occupancy cycles of a div/divu
- MEM_TIMEOUT, 255, memory-wait cycles before mem_err sets
- CNT_W, 16, width of stall_count

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_jump  in  1  j/jal/jr in ID
- id_mdu_start  in  1  ID holds mult/div about to issue
- id_mdu_div  in  1  qualifies id_mdu_start: 1 = div, 0 = mult
- id_mdu_use  in  1  ID holds mfhi/mflo/mthi/mtlo or another mult/div
- ex_mem_read  in  1  load in EX
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req, mem_ready  in  1 each  data-memory handshake
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  stage register enables
- ifid_flush, idex_flush  out  1 each  synchronous bubble insert; ifid_flush drives IF/ID `hazard`
- mdu_busy  out  1  MDU occupied
- mdu_done  out  1  one-cycle pulse on last busy cycle
- mem_err  out  1  sticky timeout flag
- stall_count  out  CNT_W  saturating count of cycles with pc_we=0

## Operation
- Combinational hazard terms:
  - freeze = mem_req & ~mem_ready
  - load_use = ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))
  - mdu_hz = mdu_busy & id_mdu_use
- Priority, highest first:
  1. freeze: all *_we=0, both flushes 0. Holds the whole pipe.
  2. ex_branch_taken: pc_we=1, ifid_flush=1, idex_flush=1. Squashes IF and ID.
  3. mdu_hz or load_use: pc_we=0, ifid_we=0, idex_flush=1. Bubble into EX.
  4. id_jump: ifid_flush=1.
  5. Otherwise all *_we=1, flushes 0.
- Whenever not frozen, idex_we, exmem_we and memwb_we are 1.
- FSM states: IDLE, MDU_BUSY.
  - IDLE→MDU_BUSY when id_mdu_start is set, priority levels 1–3 are inactive and ID advances. Counter loads DIV_CYCLES-1 or MULT_CYCLES-1.
  - In MDU_BUSY the counter decrements each non-frozen cycle.
  - At count 0 and not frozen: mdu_done=1, next state IDLE.
  - A branch flush does not abort MDU_BUSY; the op has already issued.
  - An id_mdu_start while busy is blocked by mdu_hz, because the decoder also sets id_mdu_use for it.
- Memory watchdog: wait counter increments while freeze=1 and clears when freeze=0. Reaching MEM_TIMEOUT sets mem_err, which holds until rst.
- stall_count increments on every cycle with pc_we=0 and saturates at all-ones.

## Timing
- Enables and flushes are combinational from the current state and inputs, and are sampled by stage registers at the next posedge.
- Load-use costs exactly 1 bubble cycle. Taken branch costs 2 squashed slots. Jump costs 1.
- mult occupies MULT_CYCLES cycles and div occupies DIV_CYCLES cycles, counted from the cycle after issue; frozen cycles are excluded. mdu_busy is 1 for exactly that many cycles.
- Reset (async): state=IDLE; counters=0; mem_err=0; stall_count=0; mdu_busy=0; mdu_done=0.
  - With inputs quiet, outputs are all *_we=1 and flushes 0.
  - rst mid-MDU_BUSY aborts to IDLE immediately.
- Simultaneous freeze and ex_branch_taken: freeze wins. The branch is re-evaluated when the pipe releases, because the EX contents are held.

## Structure
- Package pipeline_ctrl_pkg: FSM state enum; opcode-independent constants MULT_CYCLES_DEF=4, DIV_CYCLES_DEF=32; enable-vector bit indices.
- Sub-module mdu_timer: load value, decrement-with-enable, busy/done outputs. Instantiated once.
- The top holds the priority logic, watchdog and stall counter.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle → pc_we=0, ifid_we=0, idex_flush=1 that cycle only; stall_count 0→1.
- Branch during load-use: same as above plus ex_branch_taken=1 → pc_we=1, ifid_flush=1, idex_flush=1; stall_count unchanged.
- Div then mflo: id_mdu_start=1, id_mdu_div=1 → mdu_busy for 32 cycles. The mflo with id_mdu_use=1 stalls until mdu_done, then advances the next cycle.
- Mult with freeze: start mult, hold mem_req=1, mem_ready=0 for 3 cycles mid-op → mdu_busy spans 4+3=7 cycles; all *_we=0 during the freeze.
- Timeout: mem_req=1, mem_ready=0 for 255 cycles → mem_err=1 and stays 1 after mem_ready rises; clears only on rst.
- Async reset mid-div at count 10 → mdu_busy=0, stall_count=0 immediately, without waiting for a clock edge.
